// File: rtl/demux_striping_if.sv
// Bundle between the word source and the lane striper: one input word
// stream and two lane outputs, plus the selector that shows which lane
// takes the next word.
// Optional macro: STRIPING_STATS_EN adds per-lane word counters and a
// realign pulse.
interface demux_striping_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] data_in;
    logic              valid_in;
    logic [DATA_W-1:0] data_out0;
    logic              valid_out0;
    logic [DATA_W-1:0] data_out1;
    logic              valid_out1;
    logic              lane_sel;
`ifdef STRIPING_STATS_EN
    logic [15:0]       word_cnt0;
    logic [15:0]       word_cnt1;
    logic              realign_pulse;
`endif

    // Word source side: drives the stream and observes the lanes.
    modport master (
        output data_in,
        output valid_in,
        input  data_out0,
        input  valid_out0,
        input  data_out1,
        input  valid_out1,
`ifdef STRIPING_STATS_EN
        input  word_cnt0,
        input  word_cnt1,
        input  realign_pulse,
`endif
        input  lane_sel
    );

    // Striper side: consumes the stream and drives the lanes.
    modport slave (
        input  data_in,
        input  valid_in,
        output data_out0,
        output valid_out0,
        output data_out1,
        output valid_out1,
`ifdef STRIPING_STATS_EN
        output word_cnt0,
        output word_cnt1,
        output realign_pulse,
`endif
        output lane_sel
    );
endinterface

// File: rtl/demux_striping.sv
// Transmit-side lane striper. Consecutive valid words arriving at clk_2f
// are written alternately to lane 0 and lane 1. Each lane output is held
// valid for two clk_2f cycles so clk_f logic downstream can sample it.
// After IDLE_REALIGN idle cycles the selector returns to lane 0 so every
// new burst starts on lane 0.
// Optional macro: STRIPING_STATS_EN adds word_cnt0/word_cnt1 (saturating
// per-lane word counts) and realign_pulse (one cycle whenever an idle
// realign moves the selector from lane 1 back to lane 0).
module demux_striping #(
    parameter int DATA_W       = 32,
    parameter int IDLE_REALIGN = 2
) (
    input  logic            clk_2f,
    input  logic            reset_L,
    demux_striping_if.slave bus
);

    localparam logic [3:0] REALIGN_CNT = 4'(IDLE_REALIGN);

    // Idle counter increment that stops at the realign threshold.
    function automatic logic [3:0] idle_inc(input logic [3:0] cnt);
        if (cnt >= REALIGN_CNT) begin
            return cnt;
        end else begin
            return cnt + 4'd1;
        end
    endfunction

    // Word counter increment that stops at all-ones.
    function automatic logic [15:0] cnt_inc(input logic [15:0] cnt);
        if (cnt == 16'hFFFF) begin
            return cnt;
        end else begin
            return cnt + 16'd1;
        end
    endfunction

    logic [DATA_W-1:0] data0_r;
    logic [DATA_W-1:0] data1_r;
    logic              valid0_r;
    logic              valid1_r;
    logic              hold0_r;
    logic              hold1_r;
    logic              lane_sel_r;
    logic [3:0]        idle_cnt_r;

    logic              wr0_s;
    logic              wr1_s;
    logic              lane_sel_s;
    logic [3:0]        idle_cnt_s;
    logic              realign_s;

    // Lane write strobes and selector / idle-counter next state.
    always_comb begin
        wr0_s      = 1'b0;
        wr1_s      = 1'b0;
        lane_sel_s = lane_sel_r;
        idle_cnt_s = idle_cnt_r;
        realign_s  = 1'b0;
        if (bus.valid_in) begin
            wr0_s      = ~lane_sel_r;
            wr1_s      = lane_sel_r;
            lane_sel_s = ~lane_sel_r;
            idle_cnt_s = 4'd0;
        end else begin
            idle_cnt_s = idle_inc(idle_cnt_r);
            if (idle_cnt_s == REALIGN_CNT) begin
                lane_sel_s = 1'b0;
                realign_s  = lane_sel_r;
            end else begin
                lane_sel_s = lane_sel_r;
            end
        end
    end

    // Lane registers: write on strobe, otherwise stretch valid one extra cycle.
    always_ff @(posedge clk_2f or negedge reset_L) begin
        if (!reset_L) begin
            data0_r    <= '0;
            data1_r    <= '0;
            valid0_r   <= 1'b0;
            valid1_r   <= 1'b0;
            hold0_r    <= 1'b0;
            hold1_r    <= 1'b0;
            lane_sel_r <= 1'b0;
            idle_cnt_r <= 4'd0;
        end else begin
            lane_sel_r <= lane_sel_s;
            idle_cnt_r <= idle_cnt_s;
            if (wr0_s) begin
                data0_r  <= bus.data_in;
                valid0_r <= 1'b1;
                hold0_r  <= 1'b1;
            end else if (hold0_r) begin
                hold0_r  <= 1'b0;
            end else begin
                valid0_r <= 1'b0;
            end
            if (wr1_s) begin
                data1_r  <= bus.data_in;
                valid1_r <= 1'b1;
                hold1_r  <= 1'b1;
            end else if (hold1_r) begin
                hold1_r  <= 1'b0;
            end else begin
                valid1_r <= 1'b0;
            end
        end
    end

    assign bus.data_out0  = data0_r;
    assign bus.valid_out0 = valid0_r;
    assign bus.data_out1  = data1_r;
    assign bus.valid_out1 = valid1_r;
    assign bus.lane_sel   = lane_sel_r;

`ifdef STRIPING_STATS_EN
    logic [15:0] word_cnt0_r;
    logic [15:0] word_cnt1_r;
    logic        realign_pulse_r;

    // Per-lane word counters and the registered realign pulse.
    always_ff @(posedge clk_2f or negedge reset_L) begin
        if (!reset_L) begin
            word_cnt0_r     <= 16'd0;
            word_cnt1_r     <= 16'd0;
            realign_pulse_r <= 1'b0;
        end else begin
            realign_pulse_r <= realign_s;
            if (wr0_s) begin
                word_cnt0_r <= cnt_inc(word_cnt0_r);
            end else begin
                word_cnt0_r <= word_cnt0_r;
            end
            if (wr1_s) begin
                word_cnt1_r <= cnt_inc(word_cnt1_r);
            end else begin
                word_cnt1_r <= word_cnt1_r;
            end
        end
    end

    assign bus.word_cnt0     = word_cnt0_r;
    assign bus.word_cnt1     = word_cnt1_r;
    assign bus.realign_pulse = realign_pulse_r;
`else
    logic unused_realign_s;
    assign unused_realign_s = realign_s;
`endif

endmodule

// File: tb/tb_demux_striping.sv
// Directed bench for demux_striping (DATA_W=32, IDLE_REALIGN=2).
// Inputs change 1 time unit after each rising edge; outputs are checked
// at the same point, i.e. after the edge that registered them.
module tb_demux_striping;

    logic clk_2f;
    logic reset_L;
    int   n_checks;
    int   n_errors;

    demux_striping_if #(.DATA_W(32)) bus ();

    demux_striping #(
        .DATA_W       (32),
        .IDLE_REALIGN (2)
    ) dut (
        .clk_2f  (clk_2f),
        .reset_L (reset_L),
        .bus     (bus)
    );

    initial clk_2f = 1'b0;
    always #5 clk_2f = ~clk_2f;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_2f);
        #1;
    endtask

    task automatic send(input logic v, input logic [31:0] d);
        bus.valid_in = v;
        bus.data_in  = d;
        tick();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_d0"}, bus.data_out0, 32'h0);
        check({tag, "_v0"}, {31'd0, bus.valid_out0}, 32'd0);
        check({tag, "_d1"}, bus.data_out1, 32'h0);
        check({tag, "_v1"}, {31'd0, bus.valid_out1}, 32'd0);
        check({tag, "_sel"}, {31'd0, bus.lane_sel}, 32'd0);
`ifdef STRIPING_STATS_EN
        check({tag, "_cnt0"}, {16'd0, bus.word_cnt0}, 32'd0);
        check({tag, "_cnt1"}, {16'd0, bus.word_cnt1}, 32'd0);
`endif
    endtask

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        reset_L      = 1'b0;
        bus.valid_in = 1'b0;
        bus.data_in  = 32'h0;

        // Power-on reset
        tick();
        tick();
        check_all_zero("por");
        reset_L = 1'b1;

        // Single word then idle: two valid cycles, value retained, realign
        send(1'b1, 32'h12345678);
        check("single_d0", bus.data_out0, 32'h12345678);
        check("single_v0_c1", {31'd0, bus.valid_out0}, 32'd1);
        check("single_v1", {31'd0, bus.valid_out1}, 32'd0);
        check("single_sel1", {31'd0, bus.lane_sel}, 32'd1);
        send(1'b0, 32'hFFFFFFFF);
        check("single_v0_c2", {31'd0, bus.valid_out0}, 32'd1);
        check("single_sel_idle1", {31'd0, bus.lane_sel}, 32'd1);
        send(1'b0, 32'h0);
        check("single_v0_c3", {31'd0, bus.valid_out0}, 32'd0);
        check("single_d0_keep", bus.data_out0, 32'h12345678);
        check("single_sel_realign", {31'd0, bus.lane_sel}, 32'd0);

        // Continuous stream A0000001..A0000006
        send(1'b1, 32'hA0000001);
        check("str1_d0", bus.data_out0, 32'hA0000001);
        check("str1_v0", {31'd0, bus.valid_out0}, 32'd1);
        check("str1_v1", {31'd0, bus.valid_out1}, 32'd0);
        send(1'b1, 32'hA0000002);
        check("str2_d1", bus.data_out1, 32'hA0000002);
        check("str2_d0", bus.data_out0, 32'hA0000001);
        check("str2_v0", {31'd0, bus.valid_out0}, 32'd1);
        check("str2_v1", {31'd0, bus.valid_out1}, 32'd1);
        send(1'b1, 32'hA0000003);
        check("str3_d0", bus.data_out0, 32'hA0000003);
        check("str3_d1", bus.data_out1, 32'hA0000002);
        check("str3_v0", {31'd0, bus.valid_out0}, 32'd1);
        check("str3_v1", {31'd0, bus.valid_out1}, 32'd1);
        send(1'b1, 32'hA0000004);
        check("str4_d1", bus.data_out1, 32'hA0000004);
        check("str4_v0", {31'd0, bus.valid_out0}, 32'd1);
        check("str4_v1", {31'd0, bus.valid_out1}, 32'd1);
        send(1'b1, 32'hA0000005);
        check("str5_d0", bus.data_out0, 32'hA0000005);
        check("str5_v1", {31'd0, bus.valid_out1}, 32'd1);
        send(1'b1, 32'hA0000006);
        check("str6_d1", bus.data_out1, 32'hA0000006);
        check("str6_d0", bus.data_out0, 32'hA0000005);
        check("str6_v0", {31'd0, bus.valid_out0}, 32'd1);
        check("str6_v1", {31'd0, bus.valid_out1}, 32'd1);
        check("str6_sel", {31'd0, bus.lane_sel}, 32'd0);
        send(1'b0, 32'h0);
        check("str_tail1_v0", {31'd0, bus.valid_out0}, 32'd0);
        check("str_tail1_v1", {31'd0, bus.valid_out1}, 32'd1);
        send(1'b0, 32'h0);
        check("str_tail2_v1", {31'd0, bus.valid_out1}, 32'd0);
        check("str_tail2_d1", bus.data_out1, 32'hA0000006);

        // Gapped odd burst: one idle cycle is below the realign threshold
        send(1'b1, 32'hBEEF0001);
        send(1'b1, 32'hBEEF0002);
        send(1'b1, 32'hBEEF0003);
        check("gap_d0", bus.data_out0, 32'hBEEF0003);
        check("gap_sel", {31'd0, bus.lane_sel}, 32'd1);
        send(1'b0, 32'h0);
        check("gap_sel_idle", {31'd0, bus.lane_sel}, 32'd1);
        send(1'b1, 32'hBEEF0004);
        check("gap_d1", bus.data_out1, 32'hBEEF0004);
        check("gap_v1", {31'd0, bus.valid_out1}, 32'd1);
        check("gap_v0", {31'd0, bus.valid_out0}, 32'd0);
        check("gap_d0_keep", bus.data_out0, 32'hBEEF0003);
        check("gap_sel_after", {31'd0, bus.lane_sel}, 32'd0);
        send(1'b0, 32'h0);
        send(1'b0, 32'h0);

        // Reset mid-burst: outputs clear asynchronously, held word discarded
        send(1'b1, 32'hD0000001);
        send(1'b1, 32'hD0000002);
        check("mid_v0", {31'd0, bus.valid_out0}, 32'd1);
        check("mid_v1", {31'd0, bus.valid_out1}, 32'd1);
        bus.valid_in = 1'b1;
        bus.data_in  = 32'hD0000003;
        #2;
        reset_L = 1'b0;
        #1;
        check_all_zero("mid_async");
        tick();
        check_all_zero("mid_held");
        reset_L = 1'b1;
        send(1'b1, 32'hE0000001);
        check("post_d0", bus.data_out0, 32'hE0000001);
        check("post_v0", {31'd0, bus.valid_out0}, 32'd1);
        check("post_v1", {31'd0, bus.valid_out1}, 32'd0);
        check("post_d1", bus.data_out1, 32'h0);
        check("post_sel", {31'd0, bus.lane_sel}, 32'd1);
`ifdef STRIPING_STATS_EN
        check("post_cnt0", {16'd0, bus.word_cnt0}, 32'd1);
        check("post_cnt1", {16'd0, bus.word_cnt1}, 32'd0);
`endif

        // Realign: fresh reset, 3 words, 2 idle cycles, next word on lane 0
        bus.valid_in = 1'b0;
        reset_L      = 1'b0;
        tick();
        reset_L      = 1'b1;
        send(1'b1, 32'hCAFE0001);
        send(1'b1, 32'hCAFE0002);
        send(1'b1, 32'hCAFE0003);
        check("ra_sel_burst", {31'd0, bus.lane_sel}, 32'd1);
        send(1'b0, 32'h0);
        check("ra_sel_idle1", {31'd0, bus.lane_sel}, 32'd1);
`ifdef STRIPING_STATS_EN
        check("ra_pulse_idle1", {31'd0, bus.realign_pulse}, 32'd0);
`endif
        send(1'b0, 32'h0);
        check("ra_sel_idle2", {31'd0, bus.lane_sel}, 32'd0);
`ifdef STRIPING_STATS_EN
        check("ra_pulse_idle2", {31'd0, bus.realign_pulse}, 32'd1);
`endif
        send(1'b1, 32'hCAFE0005);
        check("ra_d0", bus.data_out0, 32'hCAFE0005);
        check("ra_v0", {31'd0, bus.valid_out0}, 32'd1);
        check("ra_d1", bus.data_out1, 32'hCAFE0002);
        check("ra_sel_after", {31'd0, bus.lane_sel}, 32'd1);
`ifdef STRIPING_STATS_EN
        check("ra_pulse_after", {31'd0, bus.realign_pulse}, 32'd0);
        check("ra_cnt0", {16'd0, bus.word_cnt0}, 32'd3);
        check("ra_cnt1", {16'd0, bus.word_cnt1}, 32'd1);
`endif
        send(1'b0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
